// File: rtl/noc_output_port_arbiter_if.sv
// Handshake bundle between an output-port arbiter and its surroundings.
// The arbiter connects through the slave modport. Upstream and downstream
// logic (or a bench) connects through the master modport.
// Optional: NOC_ARB_STATS_EN adds the 16-bit completed-packet counter.
interface noc_output_port_arbiter_if #(
    parameter int Depth = 4
) ();
    localparam int CntWidth = $clog2(Depth + 1);

    logic [4:0]          req;
    logic [4:0]          head;
    logic [4:0]          tail;
    logic                credit;
    logic [4:0]          grant;
    logic [2:0]          sel;
    logic                fwd;
    logic [CntWidth-1:0] credits;
    logic                locked;
`ifdef NOC_ARB_STATS_EN
    logic [15:0]         pkt_count;
`endif

    modport master (
        output req, head, tail, credit,
`ifdef NOC_ARB_STATS_EN
        input  pkt_count,
`endif
        input  grant, sel, fwd, credits, locked
    );

    modport slave (
        input  req, head, tail, credit,
`ifdef NOC_ARB_STATS_EN
        output pkt_count,
`endif
        output grant, sel, fwd, credits, locked
    );
endinterface

// File: rtl/noc_output_port_arbiter.sv
// Wormhole round-robin arbiter for one router output port.
// Inputs are numbered N=0, S=1, W=2, E=3, Local=4.
// A grant holds from the head flit to the tail flit. A downstream credit
// counter gates every forward. The grant is combinational, so the flit moves
// in the same cycle. State, pointer and credits update on the next edge.
// Optional: NOC_ARB_STATS_EN adds the pkt_count register and port.
module noc_output_port_arbiter #(
    parameter logic [4:0] PortEnable = 5'b11111,
    parameter int         Depth      = 4
) (
    input logic                       clk,
    input logic                       rst,
    noc_output_port_arbiter_if.slave  port
);
    localparam int CntWidth = $clog2(Depth + 1);
    localparam logic [CntWidth-1:0] FullCredits = CntWidth'(Depth);

    typedef enum logic [2:0] {
        kNorthPort = 3'd0,
        kSouthPort = 3'd1,
        kWestPort  = 3'd2,
        kEastPort  = 3'd3,
        kLocalPort = 3'd4
    } noc_port_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [2:0]          owner_reg, owner_next;
    logic [2:0]          rr_ptr_reg, rr_ptr_next;
    logic [CntWidth-1:0] credits_reg, credits_next;

    logic [4:0] cand;
    logic [4:0] grant;
    logic [2:0] sel;
    logic [2:0] winner;
    logic       winner_found;
    logic       avail;
    logic       fwd;
    logic       pkt_done;

    // (base + off) mod 5 for base, off in 0..4
    function automatic logic [2:0] wrap5(input logic [2:0] base, input logic [2:0] off);
        logic [3:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= 4'd5) begin
            s = s - 4'd5;
        end
        return s[2:0];
    endfunction

    // Arbitration candidates: head flits from enabled inputs only
    for (genvar gi = 0; gi < 5; gi++) begin : g_cand
        assign cand[gi] = port.req[gi] & port.head[gi] & PortEnable[gi];
    end

    assign avail = (credits_reg != '0);

    // Round-robin search: the first candidate at or after rr_ptr wins.
    // Walk the offsets from largest to smallest so the smallest offset is kept.
    always_comb begin
        winner       = kNorthPort;
        winner_found = 1'b0;
        for (int k = 4; k >= 0; k--) begin
            if (cand[wrap5(rr_ptr_reg, 3'(k))]) begin
                winner       = wrap5(rr_ptr_reg, 3'(k));
                winner_found = 1'b1;
            end
        end
    end

    // Next-state, grant and select logic; reset forces every output idle
    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        rr_ptr_next = rr_ptr_reg;
        grant       = '0;
        sel         = kNorthPort;
        pkt_done    = 1'b0;
        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    if (winner_found && avail) begin
                        grant[winner] = 1'b1;
                        sel           = winner;
                        if (port.tail[winner]) begin
                            rr_ptr_next = wrap5(winner, 3'd1);
                            pkt_done    = 1'b1;
                        end else begin
                            state_next = LOCKED;
                            owner_next = winner;
                        end
                    end
                end
                LOCKED: begin
                    // Only the owner may move; a gap in its request keeps the lock
                    if (port.req[owner_reg] && avail) begin
                        grant[owner_reg] = 1'b1;
                        sel              = owner_reg;
                        if (port.tail[owner_reg]) begin
                            state_next  = IDLE;
                            rr_ptr_next = wrap5(owner_reg, 3'd1);
                            pkt_done    = 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign fwd = |grant;

    // Credit counter: a forward spends one credit, a return refunds one, saturating at Depth
    always_comb begin
        credits_next = credits_reg;
        case ({fwd, port.credit})
            2'b10:   credits_next = credits_reg - 1'b1;
            2'b01:   credits_next = (credits_reg == FullCredits) ? credits_reg : credits_reg + 1'b1;
            default: credits_next = credits_reg;
        endcase
    end

    // State, owner, pointer and credit registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            owner_reg   <= kNorthPort;
            rr_ptr_reg  <= 3'd0;
            credits_reg <= FullCredits;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            rr_ptr_reg  <= rr_ptr_next;
            credits_reg <= credits_next;
        end
    end

`ifdef NOC_ARB_STATS_EN
    logic [15:0] pkt_count_reg;

    // Completed-packet counter; wraps at 16 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_reg <= 16'd0;
        end else if (pkt_done) begin
            pkt_count_reg <= pkt_count_reg + 16'd1;
        end
    end

    assign port.pkt_count = pkt_count_reg;
`else
    logic unused_pkt_done;
    assign unused_pkt_done = pkt_done;
`endif

    assign port.grant   = grant;
    assign port.sel     = sel;
    assign port.fwd     = fwd;
    assign port.credits = credits_reg;
    assign port.locked  = !rst && (state_reg == LOCKED);

    // Protocol checks: credit overflow and non-head requests while idle
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(port.credit && !fwd && credits_reg == FullCredits))
                else $warning("credit returned while counter already at Depth");
            assert (!(state_reg == IDLE && |(port.req & ~port.head & PortEnable)))
                else $warning("non-head request while idle");
        end
    end
endmodule
